// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit for the schoolRISCV core.
// Takes the effective address, store data and funct3 size code from the core
// and runs a req/ack transaction on a word-organised data memory. It returns
// byte-lane-aligned, sign- or zero-extended load data.
// A watchdog aborts accesses that are never acknowledged.
// Parameter: TIMEOUT = max BUSY cycles waiting for dmAck (0 disables it).
// Macro: SR_LSU_MISALIGN_EN makes misaligned half/word accesses complete
//        as errors with no memory access.
// Ports:
//   clk, rst (sync, active-high)
//   CPU side: lsuReq, lsuWe, lsuF3, lsuAddr, lsuWdata
//             -> lsuRdata, lsuDone, lsuErr, lsuStall
//   mem side: dmReq, dmWe, dmBe, dmAddr, dmWdata <- dmAck, dmRdata
module sr_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsuReq,
    input  logic        lsuWe,
    input  logic [2:0]  lsuF3,
    input  logic [31:0] lsuAddr,
    input  logic [31:0] lsuWdata,
    output logic [31:0] lsuRdata,
    output logic        lsuDone,
    output logic        lsuErr,
    output logic        lsuStall,
    output logic        dmReq,
    output logic        dmWe,
    output logic [3:0]  dmBe,
    output logic [31:0] dmAddr,
    output logic [31:0] dmWdata,
    input  logic        dmAck,
    input  logic [31:0] dmRdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_done_q, lsu_done_d;
    logic        lsu_err_q, lsu_err_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] cnt_q, cnt_d;

    logic        misal;
    logic        op_bad;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        timeout_hit;

    // Request-side decode: validity, store lanes.
    always_comb begin
`ifdef SR_LSU_MISALIGN_EN
        misal = ((lsuF3[1:0] == 2'b01) && lsuAddr[0])
              || ((lsuF3[1:0] == 2'b10) && (lsuAddr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        op_bad = (lsuF3[1:0] == 2'b11) || misal;
        case (lsuF3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << lsuAddr[1:0];
                st_data = {4{lsuWdata[7:0]}};
            end
            2'b01: begin
                st_be   = lsuAddr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{lsuWdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = lsuWdata;
            end
        endcase
    end

    // Response-side lane extraction, from the latched address/size.
    always_comb begin
        ld_byte = dmRdata[{addr_lo_q, 3'b000} +: 8];
        ld_half = dmRdata[{addr_lo_q[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   ld_data = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = dmRdata;
        endcase
        if (dm_we_q) begin
            ld_data = 32'd0;
        end
    end

    // Counter holds the number of BUSY cycles already elapsed.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_be_d     = dm_be_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        lsu_rdata_d = lsu_rdata_q;
        lsu_done_d  = 1'b0;
        lsu_err_d   = 1'b0;
        addr_lo_d   = addr_lo_q;
        f3_d        = f3_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                lsu_rdata_d = 32'd0;
                if (lsuReq) begin
                    addr_lo_d  = lsuAddr[1:0];
                    f3_d       = lsuF3;
                    dm_addr_d  = {2'b00, lsuAddr[31:2]};
                    dm_we_d    = lsuWe;
                    dm_be_d    = lsuWe ? st_be : 4'b1111;
                    dm_wdata_d = st_data;
                    cnt_d      = 32'd0;
                    if (op_bad) begin
                        state_d    = S_DONE;
                        lsu_done_d = 1'b1;
                        lsu_err_d  = 1'b1;
                    end else begin
                        state_d  = S_BUSY;
                        dm_req_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 32'd1;
                // An ack in the timeout cycle still completes normally.
                if (dmAck) begin
                    state_d     = S_DONE;
                    dm_req_d    = 1'b0;
                    lsu_rdata_d = ld_data;
                    lsu_done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = S_DONE;
                    dm_req_d    = 1'b0;
                    lsu_rdata_d = 32'd0;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                lsu_rdata_d = 32'd0;
            end
            default: begin
                state_d  = S_IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_be_q     <= 4'b0000;
            dm_addr_q   <= 32'd0;
            dm_wdata_q  <= 32'd0;
            lsu_rdata_q <= 32'd0;
            lsu_done_q  <= 1'b0;
            lsu_err_q   <= 1'b0;
            addr_lo_q   <= 2'b00;
            f3_q        <= 3'b000;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_be_q     <= dm_be_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_done_q  <= lsu_done_d;
            lsu_err_q   <= lsu_err_d;
            addr_lo_q   <= addr_lo_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dmReq    = dm_req_q;
    assign dmWe     = dm_we_q;
    assign dmBe     = dm_be_q;
    assign dmAddr   = dm_addr_q;
    assign dmWdata  = dm_wdata_q;
    assign lsuRdata = lsu_rdata_q;
    assign lsuDone  = lsu_done_q;
    assign lsuErr   = lsu_err_q;
    assign lsuStall = lsuReq & ~lsu_done_q;

endmodule

// File: tb/tb_sr_lsu.sv
// Testbench for sr_lsu: table-driven load/store vectors with a small
// acking memory, plus hand-written timeout, late-ack and reset sequences.
module tb_sr_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsuReq, lsuWe;
    logic [2:0]  lsuF3;
    logic [31:0] lsuAddr, lsuWdata;
    logic [31:0] lsuRdata;
    logic        lsuDone, lsuErr, lsuStall;
    logic        dmReq, dmWe;
    logic [3:0]  dmBe;
    logic [31:0] dmAddr, dmWdata;
    logic        dmAck;
    logic [31:0] dmRdata;

    int checks = 0;
    int errors = 0;

    sr_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .lsuReq(lsuReq), .lsuWe(lsuWe), .lsuF3(lsuF3),
        .lsuAddr(lsuAddr), .lsuWdata(lsuWdata),
        .lsuRdata(lsuRdata), .lsuDone(lsuDone), .lsuErr(lsuErr),
        .lsuStall(lsuStall),
        .dmReq(dmReq), .dmWe(dmWe), .dmBe(dmBe), .dmAddr(dmAddr),
        .dmWdata(dmWdata), .dmAck(dmAck), .dmRdata(dmRdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          dly;   // BUSY cycle index of the ack, -1 = never
        bit          mem;   // a memory access is expected
        logic [3:0]  be;
        logic [31:0] waddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic we, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [31:0] mdata, input int dly, input bit mem,
        input logic [3:0] be, input logic [31:0] waddr,
        input logic [31:0] dwdata, input logic [31:0] rdata,
        input logic err);
        vec_t t;
        t.name = nm; t.we = we; t.f3 = f3; t.addr = addr;
        t.wdata = wdata; t.mdata = mdata; t.dly = dly; t.mem = mem;
        t.be = be; t.waddr = waddr; t.dwdata = dwdata;
        t.rdata = rdata; t.err = err;
        return t;
    endfunction

    task automatic run(input vec_t t);
        int          cyc;
        int          busy;
        int          exp_busy;
        bit          done;
        bit          stable;
        bit          stall_ok;
        logic [31:0] a0;
        @(negedge clk);
        lsuReq = 1'b1; lsuWe = t.we; lsuF3 = t.f3;
        lsuAddr = t.addr; lsuWdata = t.wdata;
        cyc = 0; busy = 0; done = 0; stable = 1; stall_ok = 1; a0 = '0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            dmAck = 1'b0;
            if (lsuDone === 1'b1) begin
                done = 1;
                chk({t.name, " rdata"}, lsuRdata, t.rdata);
                chk({t.name, " err"}, {31'd0, lsuErr}, {31'd0, t.err});
                chk({t.name, " stall in done"}, {31'd0, lsuStall}, 32'd0);
                lsuReq = 1'b0;
            end else begin
                if (lsuStall !== 1'b1) stall_ok = 0;
                if (dmReq === 1'b1) begin
                    if (busy == 0) begin
                        chk({t.name, " dmBe"}, {28'd0, dmBe}, {28'd0, t.be});
                        chk({t.name, " dmAddr"}, dmAddr, t.waddr);
                        chk({t.name, " dmWe"}, {31'd0, dmWe}, {31'd0, t.we});
                        if (t.we)
                            chk({t.name, " dmWdata"}, dmWdata, t.dwdata);
                        a0 = dmAddr;
                    end else if (dmAddr !== a0) begin
                        stable = 0;
                    end
                    dmRdata = t.mdata;
                    dmAck = (busy == t.dly);
                    busy++;
                end
            end
        end
        if (!done) begin
            chk({t.name, " done seen"}, 32'd0, 32'd1);
            lsuReq = 1'b0;
            dmAck = 1'b0;
        end
        exp_busy = !t.mem ? 0 : (t.dly < 0 ? TO : t.dly + 1);
        chk({t.name, " busy cycles"}, busy, exp_busy);
        chk({t.name, " done cycle"}, cyc, exp_busy + 1);
        chk({t.name, " stall held"}, {31'd0, stall_ok}, 32'd1);
        chk({t.name, " addr stable"}, {31'd0, stable}, 32'd1);
    endtask

    initial begin
        vec_t tmo;
        vec_t lw_ok;
        rst = 1'b1; lsuReq = 1'b0; lsuWe = 1'b0; lsuF3 = 3'b000;
        lsuAddr = '0; lsuWdata = '0; dmAck = 1'b0; dmRdata = '0;

        vq.push_back(mk("sb103", 1, 3'b000, 32'h103, 32'hA5, 0, 0, 1,
                        4'b1000, 32'h40, 32'hA5A5A5A5, 32'h0, 0));
        vq.push_back(mk("lb2", 0, 3'b000, 32'h2, 0, 32'h80FF7F01, 0, 1,
                        4'b1111, 32'h0, 0, 32'hFFFFFFFF, 0));
        vq.push_back(mk("lbu2", 0, 3'b100, 32'h2, 0, 32'h80FF7F01, 0, 1,
                        4'b1111, 32'h0, 0, 32'h000000FF, 0));
        vq.push_back(mk("lh2", 0, 3'b001, 32'h2, 0, 32'h80FF7F01, 1, 1,
                        4'b1111, 32'h0, 0, 32'hFFFF80FF, 0));
        vq.push_back(mk("lhu0", 0, 3'b101, 32'h0, 0, 32'h80FF7F01, 0, 1,
                        4'b1111, 32'h0, 0, 32'h00007F01, 0));
        vq.push_back(mk("lb1", 0, 3'b000, 32'h1, 0, 32'h80FF7F01, 0, 1,
                        4'b1111, 32'h0, 0, 32'h0000007F, 0));
        vq.push_back(mk("lw_wait2", 0, 3'b010, 32'h10, 0, 32'h12345678,
                        2, 1, 4'b1111, 32'h4, 0, 32'h12345678, 0));
        vq.push_back(mk("lw_ack_at_to", 0, 3'b010, 32'h44, 0, 32'h0BADF00D,
                        TO - 1, 1, 4'b1111, 32'h11, 0, 32'h0BADF00D, 0));
        vq.push_back(mk("sh22", 1, 3'b001, 32'h22, 32'hDEADBEEF, 0, 0, 1,
                        4'b1100, 32'h8, 32'hBEEFBEEF, 32'h0, 0));
        vq.push_back(mk("sb0", 1, 3'b000, 32'h0, 32'h12345601, 0, 1, 1,
                        4'b0001, 32'h0, 32'h01010101, 32'h0, 0));
        vq.push_back(mk("sw30", 1, 3'b010, 32'h30, 32'hCAFEF00D, 0, 0, 1,
                        4'b1111, 32'hC, 32'hCAFEF00D, 32'h0, 0));
        vq.push_back(mk("rsvd", 0, 3'b011, 32'h8, 0, 32'h11111111, 0, 0,
                        4'b1111, 32'h2, 0, 32'h0, 1));
`ifdef SR_LSU_MISALIGN_EN
        vq.push_back(mk("lw6", 0, 3'b010, 32'h6, 0, 32'hAABBCCDD, 0, 0,
                        4'b1111, 32'h1, 0, 32'h0, 1));
        vq.push_back(mk("lh3", 0, 3'b001, 32'h3, 0, 32'h80FF7F01, 0, 0,
                        4'b1111, 32'h0, 0, 32'h0, 1));
`else
        vq.push_back(mk("lw6", 0, 3'b010, 32'h6, 0, 32'hAABBCCDD, 0, 1,
                        4'b1111, 32'h1, 0, 32'hAABBCCDD, 0));
        vq.push_back(mk("lh3", 0, 3'b001, 32'h3, 0, 32'h80FF7F01, 0, 1,
                        4'b1111, 32'h0, 0, 32'hFFFF80FF, 0));
`endif
        tmo = mk("timeout", 0, 3'b010, 32'h40, 0, 32'h55555555, -1, 1,
                 4'b1111, 32'h10, 0, 32'h0, 1);
        lw_ok = mk("lw_after", 0, 3'b010, 32'h20, 0, 32'h13579BDF, 0, 1,
                   4'b1111, 32'h8, 0, 32'h13579BDF, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dmReq", {31'd0, dmReq}, 32'd0);
        chk("rst dmWe", {31'd0, dmWe}, 32'd0);
        chk("rst dmBe", {28'd0, dmBe}, 32'd0);
        chk("rst dmAddr", dmAddr, 32'd0);
        chk("rst dmWdata", dmWdata, 32'd0);
        chk("rst lsuRdata", lsuRdata, 32'd0);
        chk("rst lsuDone", {31'd0, lsuDone}, 32'd0);
        chk("rst lsuErr", {31'd0, lsuErr}, 32'd0);
        rst = 1'b0;

        foreach (vq[i]) run(vq[i]);

        // Timeout, then a late ack in IDLE must be ignored.
        run(tmo);
        @(negedge clk);
        dmAck = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmAck = 1'b0;
        chk("late ack done", {31'd0, lsuDone}, 32'd0);
        chk("late ack dmReq", {31'd0, dmReq}, 32'd0);
        run(lw_ok);

        // Reset while BUSY drops the op without lsuDone.
        @(negedge clk);
        lsuReq = 1'b1; lsuWe = 1'b0; lsuF3 = 3'b010;
        lsuAddr = 32'h50; lsuWdata = '0;
        @(posedge clk);
        @(negedge clk);
        chk("pre-rst dmReq", {31'd0, dmReq}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-rst dmReq", {31'd0, dmReq}, 32'd0);
        chk("mid-rst lsuDone", {31'd0, lsuDone}, 32'd0);
        chk("mid-rst dmAddr", dmAddr, 32'd0);
        chk("mid-rst dmBe", {28'd0, dmBe}, 32'd0);
        rst = 1'b0;
        lsuReq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst lsuDone", {31'd0, lsuDone}, 32'd0);
        run(lw_ok);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
